// File: rtl/load_store_unit.sv
// Purpose : RV32I load/store sequencer that drives a single-outstanding valid/ready data bus (RAM + UART MMIO).
// Latency : a fault completes 1 cycle after the request; a bus access completes 2 cycles after it, plus 1 per wait state.
// Backpress: stall is held while an op is in flight; a bus request holds its fields until bus_ready or timeout.
//
// Ports:
//   clk, reset                      rising-edge clock, asynchronous active-high reset
//   req_valid/write/funct3/addr/wdata  one memory op from MEM, held stable while stall=1
//   stall, done                     pipeline freeze (combinational) and one-cycle completion pulse
//   MemData                         extended load result, valid from the done cycle onward
//   fault, fault_cause              01 misaligned, 10 illegal funct3, 11 bus timeout; valid with done
//   bus_valid/we/addr/be/wdata      bus request (registered)
//   bus_ready, bus_rdata            bus response
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] MemData,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t         state;
    logic [2:0]     op_funct3;
    logic [1:0]     op_lane;
    logic [CW-1:0]  wait_cnt;

    logic           illegal;
    logic           misaligned;
    logic [3:0]     st_be;
    logic [31:0]    st_wdata;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    ld_data;
    logic           timeout_hit;

    assign stall = req_valid & ~done;

    // Request decode. Stores only have the three signed widths; the
    // unsigned encodings are load-only.
    always_comb begin
        illegal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = req_write;
            default:                illegal = 1'b1;
        endcase
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // Store lane placement: data is replicated across the word so the
    // byte enables alone select the target lane.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = 32'h0;
        if (req_write) begin
            case (req_funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << req_addr[1:0];
                    st_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = req_wdata;
                end
            endcase
        end
    end

    // Load extraction from the response word using the registered lane.
    always_comb begin
        ld_byte = bus_rdata[{op_lane, 3'b000} +: 8];
        ld_half = op_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (op_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            op_funct3   <= 3'b000;
            op_lane     <= 2'b00;
            wait_cnt    <= '0;
            bus_valid   <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_be      <= 4'h0;
            bus_wdata   <= 32'h0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            MemData     <= 32'h0;
        end else begin
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (illegal || misaligned) begin
                            // Illegal encoding takes priority over alignment.
                            state       <= S_RESP;
                            done        <= 1'b1;
                            fault       <= 1'b1;
                            fault_cause <= illegal ? 2'b10 : 2'b01;
                            if (!req_write) MemData <= 32'h0;
                        end else begin
                            state     <= S_BUS;
                            bus_valid <= 1'b1;
                            bus_we    <= req_write;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_be    <= st_be;
                            bus_wdata <= st_wdata;
                            op_funct3 <= req_funct3;
                            op_lane   <= req_addr[1:0];
                            wait_cnt  <= '0;
                        end
                    end
                end
                S_BUS: begin
                    // A ready on the timeout edge still completes normally.
                    if (bus_ready) begin
                        state     <= S_RESP;
                        bus_valid <= 1'b0;
                        done      <= 1'b1;
                        if (!bus_we) MemData <= ld_data;
                    end else if (timeout_hit) begin
                        state       <= S_RESP;
                        bus_valid   <= 1'b0;
                        done        <= 1'b1;
                        fault       <= 1'b1;
                        fault_cause <= 2'b11;
                        if (!bus_we) MemData <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose : self-checking bench for load_store_unit (directed table, reset-abort sequence, randomized ops vs. model).
// Latency : measures done latency, stall and bus_valid cycle counts per op.
// Backpress: bench acts as the bus slave, inserting a per-op number of wait states.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] MemData;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .MemData(MemData),
        .fault(fault), .fault_cause(fault_cause),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] mem;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic        flt;
        logic [1:0]  cause;
        int          lat;
        int          bcyc;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem_model = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                                input logic [31:0] mem, input logic [3:0] be, input logic [31:0] bwd,
                                input logic flt, input logic [1:0] cause, input int lat, input int bcyc);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.waits = waits;
        v.mem = mem; v.be = be; v.bwd = bwd; v.flt = flt; v.cause = cause; v.lat = lat; v.bcyc = bcyc;
        return v;
    endfunction

    // Behavioural reference: decides the outcome from access size, alignment
    // and the wait-state count, updating the architectural MemData value.
    function automatic vec_t model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        vec_t   v;
        int     size;
        int     ofs;
        logic   ok;
        longint mask;
        longint val;
        longint rep;
        v = mk(wr, f3, addr, wdata, rdata, waits, 0, 4'hF, 0, 0, 0, 0, 0);
        size = 1 << f3[1:0];
        ofs  = int'(addr % 4);
        ok   = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!ok || (addr % size != 0)) begin
            v.flt   = 1'b1;
            v.cause = ok ? 2'b01 : 2'b10;
            v.lat   = 1;
            v.bcyc  = 0;
            if (!wr) mem_model = 32'h0;
        end else begin
            v.bcyc = (waits > TO) ? TO + 1 : waits + 1;
            v.lat  = 1 + v.bcyc;
            mask   = (64'd1 << (8 * size)) - 1;
            if (wr) begin
                rep   = (size == 1) ? 64'h01010101 : (size == 2) ? 64'h00010001 : 64'd1;
                v.be  = 4'(((1 << size) - 1) << ofs);
                v.bwd = 32'((longint'(wdata) & mask) * rep);
            end else begin
                v.be  = 4'hF;
                v.bwd = 32'h0;
            end
            if (waits > TO) begin
                v.flt   = 1'b1;
                v.cause = 2'b11;
                if (!wr) mem_model = 32'h0;
            end else if (!wr) begin
                val = (longint'(rdata) >> (8 * ofs)) & mask;
                if (!f3[2] && size < 4 && val >= (64'd1 << (8 * size - 1)))
                    val = val - (64'd1 << (8 * size));
                mem_model = val[31:0];
            end
        end
        v.mem = mem_model;
        return v;
    endfunction

    task automatic run_op(input string tag, input vec_t v);
        int          cyc;
        int          bcyc;
        int          stall_cyc;
        int          done_cyc;
        logic        got_done;
        logic        held;
        logic        we0;
        logic [31:0] a0;
        logic [31:0] w0;
        logic [3:0]  be0;
        logic        flt_s;
        logic [1:0]  cause_s;
        logic [31:0] mem_s;
        cyc = 0; bcyc = 0; stall_cyc = 0; done_cyc = 0; got_done = 1'b0; held = 1'b1;
        we0 = 1'b0; a0 = 0; w0 = 0; be0 = 0; flt_s = 1'b0; cause_s = 2'b00; mem_s = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = v.wr; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        bus_ready = 1'b0;
        #1;
        if (stall) stall_cyc++;
        while (!got_done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (stall) stall_cyc++;
            if (bus_valid) begin
                bcyc++;
                if (bcyc == 1) begin
                    we0 = bus_we; a0 = bus_addr; w0 = bus_wdata; be0 = bus_be;
                end else if (bus_we !== we0 || bus_addr !== a0 || bus_wdata !== w0 || bus_be !== be0) begin
                    held = 1'b0;
                end
                bus_ready = (bcyc > v.waits);
                bus_rdata = bus_ready ? v.rdata : $urandom;
            end else begin
                bus_ready = 1'b0;
            end
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                flt_s = fault; cause_s = fault_cause; mem_s = MemData;
            end
        end
        req_valid = 1'b0;
        bus_ready = 1'b0;
        chk({tag, " done_seen"}, 32'(got_done), 32'd1);
        chk({tag, " done_latency"}, done_cyc, v.lat);
        chk({tag, " stall_cycles"}, stall_cyc, v.lat);
        chk({tag, " bus_valid_cycles"}, bcyc, v.bcyc);
        chk({tag, " fault"}, 32'(flt_s), 32'(v.flt));
        chk({tag, " fault_cause"}, 32'(cause_s), 32'(v.cause));
        chk({tag, " MemData"}, mem_s, v.mem);
        if (v.bcyc > 0) begin
            chk({tag, " bus_we"}, 32'(we0), 32'(v.wr));
            chk({tag, " bus_addr"}, a0, {v.addr[31:2], 2'b00});
            chk({tag, " bus_be"}, 32'(be0), 32'(v.be));
            chk({tag, " bus_wdata"}, w0, v.bwd);
            chk({tag, " bus_held"}, 32'(held), 32'd1);
        end
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    vec_t tbl[16];

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;

        //          wr f3   addr          wdata         rdata         w   MemData       be       bwd           f  cause lat bcyc
        tbl[0]  = mk(0, 3'd2, 32'h00000100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 4'hF,    32'h0,        0, 2'd0, 2, 1);
        tbl[1]  = mk(0, 3'd0, 32'h00000103, 32'h0,        32'h80000000, 0, 32'hFFFFFF80, 4'hF,    32'h0,        0, 2'd0, 2, 1);
        tbl[2]  = mk(0, 3'd4, 32'h00000103, 32'h0,        32'h80000000, 0, 32'h00000080, 4'hF,    32'h0,        0, 2'd0, 2, 1);
        tbl[3]  = mk(0, 3'd5, 32'h00000102, 32'h0,        32'hABCD0000, 0, 32'h0000ABCD, 4'hF,    32'h0,        0, 2'd0, 2, 1);
        tbl[4]  = mk(1, 3'd0, 32'h00000201, 32'h12345678, 32'h0,        0, 32'h0000ABCD, 4'b0010, 32'h78787878, 0, 2'd0, 2, 1);
        tbl[5]  = mk(1, 3'd1, 32'h00000202, 32'h12345678, 32'h0,        0, 32'h0000ABCD, 4'b1100, 32'h56785678, 0, 2'd0, 2, 1);
        tbl[6]  = mk(0, 3'd1, 32'h00000106, 32'h0,        32'h80017777, 0, 32'hFFFF8001, 4'hF,    32'h0,        0, 2'd0, 2, 1);
        tbl[7]  = mk(0, 3'd2, 32'h00001002, 32'h0,        32'h0,        0, 32'h00000000, 4'hF,    32'h0,        1, 2'd1, 1, 0);
        tbl[8]  = mk(0, 3'd2, 32'h00000300, 32'h0,        32'hCAFEF00D, 4, 32'hCAFEF00D, 4'hF,    32'h0,        0, 2'd0, 6, 5);
        tbl[9]  = mk(0, 3'd3, 32'h00000100, 32'h0,        32'h0,        0, 32'h00000000, 4'hF,    32'h0,        1, 2'd2, 1, 0);
        tbl[10] = mk(0, 3'd2, 32'h00000008, 32'h0,        32'h11223344, 2, 32'h11223344, 4'hF,    32'h0,        0, 2'd0, 4, 3);
        tbl[11] = mk(0, 3'd2, 32'h00000304, 32'h0,        32'h55555555, 9, 32'h00000000, 4'hF,    32'h0,        1, 2'd3, 6, 5);
        tbl[12] = mk(0, 3'd2, 32'h00000008, 32'h0,        32'h11223344, 2, 32'h11223344, 4'hF,    32'h0,        0, 2'd0, 4, 3);
        tbl[13] = mk(1, 3'd2, 32'h00000009, 32'h99999999, 32'h0,        0, 32'h11223344, 4'hF,    32'h0,        1, 2'd1, 1, 0);
        tbl[14] = mk(1, 3'd4, 32'h00000010, 32'h99999999, 32'h0,        0, 32'h11223344, 4'hF,    32'h0,        1, 2'd2, 1, 0);
        tbl[15] = mk(1, 3'd2, 32'h00000040, 32'hAABBCCDD, 32'h0,        1, 32'h11223344, 4'hF,    32'hAABBCCDD, 0, 2'd0, 3, 2);

        // Reset state.
        #12;
        chk("rst bus_valid", 32'(bus_valid), 0);
        chk("rst bus_we", 32'(bus_we), 0);
        chk("rst bus_addr", bus_addr, 0);
        chk("rst bus_be", 32'(bus_be), 0);
        chk("rst bus_wdata", bus_wdata, 0);
        chk("rst done", 32'(done), 0);
        chk("rst fault", 32'(fault), 0);
        chk("rst fault_cause", 32'(fault_cause), 0);
        chk("rst MemData", MemData, 0);
        chk("rst stall_low", 32'(stall), 0);
        req_valid = 1'b1;
        #1;
        chk("rst stall_follows", 32'(stall), 1);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i]);
        end
        mem_model = tbl[15].mem;

        // Reset pulsed during the second wait cycle of a three-wait load.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h500; bus_ready = 1'b0;
        @(negedge clk);
        chk("abort bus_cycle1", 32'(bus_valid), 1);
        @(negedge clk);
        chk("abort bus_cycle2", 32'(bus_valid), 1);
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("abort bus_valid_async", 32'(bus_valid), 0);
        chk("abort MemData_reset", MemData, 0);
        @(negedge clk);
        reset = 1'b0;
        mem_model = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort no_done", 32'(done), 0);
            chk("abort bus_idle", 32'(bus_valid), 0);
        end
        run_op("after_abort", model(1'b0, 3'd2, 32'h00000600, 32'h0, 32'h0BADF00D, 0));

        // Randomized ops against the reference model.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_op($sformatf("rnd%0d", i),
                   model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                         $urandom, $urandom, int'($urandom_range(0, 6))));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle memory-access unit of the RISC-V core. It takes one load or store per request from the MEM stage and runs it on the shared single-outstanding valid/ready data bus, which serves both data RAM and the UART MMIO registers. For stores it aligns the data and generates byte enables. For loads it returns the extracted, sign- or zero-extended word as `MemData` to the write-back selector (`MemToReg = 2'b10`). It stalls the pipeline while an access is in flight.

## Interface
- `TIMEOUT_CYCLES`, 255: bus wait-state limit before abort; 0 disables the timeout.
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: asynchronous, active-high.
- `req_valid  in  1`: a memory op is present; held stable while `stall`=1.
- `req_write  in  1`: 1 = store, 0 = load.
- `req_funct3  in  3`: RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr  in  32`: byte address (ALU result).
- `req_wdata  in  32`: store data (rs2).
- `stall  out  1`: freeze the pipeline.
- `done  out  1`: one-cycle completion pulse.
- `MemData  out  32`: extended load result.
- `fault  out  1`, `fault_cause  out  2`: fault flag and cause. Causes are 01 misaligned, 10 illegal funct3, 11 bus timeout. Both are valid with `done`.
- `bus_valid  out  1`, `bus_we  out  1`, `bus_addr  out  32`, `bus_be  out  4`, `bus_wdata  out  32`: bus request.
- `bus_ready  in  1`, `bus_rdata  in  32`: bus response.

## Operation
- States:
  - IDLE: no access in flight; waits for `req_valid`.
  - BUS: `bus_valid`=1; waits for `bus_ready` or timeout.
  - RESP: `done`=1 for exactly one cycle; always returns to IDLE.
- IDLE transitions on `req_valid`:
  - Illegal funct3 (011, 110, 111, or store with 1xx): go to RESP with `fault_cause` 10.
  - Misaligned (H/HU with addr[0]=1; W with addr[1:0]≠0): go to RESP with `fault_cause` 01.
  - Otherwise: go to BUS, registering request fields.
  - No bus transaction is issued for either fault case.
- BUS outputs, held constant until accepted:
  - `bus_addr` = {addr[31:2], 2'b00}; `bus_we` = `req_write`.
  - Byte store: `bus_be` = 4'b0001 << addr[1:0]; `bus_wdata` = byte replicated ×4.
  - Halfword store: `bus_be` = 0011 when addr[1]=0, else 1100; `bus_wdata` = halfword replicated ×2.
  - Word store: `bus_be` = 1111; `bus_wdata` = `req_wdata`.
  - Loads: `bus_be` = 1111; `bus_wdata` = 0.
- Transfer completes on a rising edge where `bus_valid` & `bus_ready`, then RESP.
- Load extraction is taken from `bus_rdata` at the accept edge, using lane = addr[1:0]:
  - B: sign-extend byte `lane`; BU: zero-extend byte `lane`.
  - H: sign-extend half `addr[1]`; HU: zero-extend half `addr[1]`; W: whole word.
- `MemData` is a register:
  - Updated only on a completed load.
  - Cleared to 0 on a faulting load.
  - Unchanged by stores and store faults.
- Timeout: a wait counter clears on entering BUS and increments each BUS cycle with `bus_ready`=0. When it equals `TIMEOUT_CYCLES` with `bus_ready` still 0:
  - `bus_valid` drops at that edge.
  - Go to RESP with `fault_cause` 11.
  - `bus_ready` arriving on that same edge wins: normal completion, no fault.
- `stall` = `req_valid` & ~`done` (combinational). The pipeline advances on the edge after `done`. A `req_valid` seen in IDLE after RESP is always a new op.

## Timing
- Reset values: state IDLE, and all of `bus_valid`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `done`, `fault`, `fault_cause`, `MemData` are 0. `stall` follows `req_valid`.
- Reset asserted mid-access: `bus_valid` drops asynchronously, nothing completes, and no `done` is issued.
- Latency with a zero-wait bus (ready=1 in the first BUS cycle):
  - Request in cycle k, BUS in k+1, `done` in k+2.
  - `stall` is high in cycles k and k+1.
- Each bus wait cycle adds one cycle. Faults complete with `done` in cycle k+1.
- `done`, `fault` and `fault_cause` are registered outputs. `MemData` is valid from the `done` cycle onward.

## Test plan
- LW addr 0x100, bus returns 0xDEADBEEF with zero wait → `bus_be` 1111; `done` in cycle k+2; `MemData` 0xDEADBEEF; `stall` high exactly 2 cycles.
- LB addr 0x103, rdata 0x80000000 → `MemData` 0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr 0x102, rdata 0xABCD0000 → 0x0000ABCD.
- SB addr 0x201, data 0x12345678 → `bus_be` 0010, `bus_wdata` 0x78787878, `bus_we` 1. SH addr 0x202 → `bus_be` 1100, `bus_wdata` 0x56785678. `MemData` unchanged.
- LW addr 0x1002 → `fault` 1, `fault_cause` 01, `done` in cycle k+1, `bus_valid` never asserted. funct3 011 → `fault_cause` 10.
- `TIMEOUT_CYCLES`=4, `bus_ready` held 0 → `bus_valid` high 5 cycles, then `done` with `fault_cause` 11 and `MemData` 0. Repeat with ready arriving on the 5th BUS cycle → normal completion.
- Three wait states, with `reset` pulsed in the second BUS cycle → `bus_valid` drops immediately, no `done`. A subsequent LW completes normally.
